io_tx_controller: RTL and testbench
===================================

IO_TX_CONTROLLER -- requirements
Module: io_tx_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries; legal values 2..8.
REQ-002 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to stream one image; sampled only while idle.
REQ-005 SHALL have port nrows  input  8  image rows; sampled with start.
REQ-006 SHALL have port ncols  input  8  image columns; sampled with start.
REQ-007 SHALL have port sram_ctrl  output  img_sram_ctrl_t  SRAM control: sense_en, write_en, row, col, din.
REQ-008 SHALL have port sram_dout  input  8  SRAM read data, valid exactly 1 cycle after the read address is presented.
REQ-009 SHALL have port dout  output  8  pixel data.
REQ-010 SHALL have port dout_valid  output  1  dout holds a pixel.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts; a beat transfers when dout_valid && dout_ready.
REQ-012 SHALL have port dout_last  output  1  current beat is the final pixel of the image.
REQ-013 SHALL have port busy  output  1  transfer in progress.

Function
REQ-014 SHALL use states IDLE, READ, DRAIN; IDLE->READ on start with nrows!=0 && ncols!=0; READ->DRAIN after the final read issues; DRAIN->IDLE when the final beat transfers.
REQ-015 SHALL ignore start with nrows==0 or ncols==0 (stay IDLE, busy 0, no reads) and ignore start outside IDLE.
REQ-016 SHALL latch nrows/ncols on start; input changes during a transfer have no effect.
REQ-017 SHALL issue reads in row-major order: (0,0),(0,1)..(0,ncols-1),(1,0)..(nrows-1,ncols-1), each address exactly once.
REQ-018 SHALL issue a read in a cycle only when FIFO occupancy plus in-flight reads < FIFO_DEPTH; no pixel is ever dropped or duplicated.
REQ-019 SHALL drive sram_ctrl.sense_en=1 in read-issue cycles and 0 otherwise; write_en=0 and din=0 at all times; row/col hold the issued address.
REQ-020 SHALL write sram_dout into the FIFO on the cycle after each read issue.
REQ-021 SHALL drive dout_valid whenever the FIFO is non-empty, dout from the FIFO head; dout/dout_valid hold stable while dout_valid && !dout_ready.
REQ-022 SHALL achieve latency: start in cycle 0, first read in cycle 1, first dout_valid in cycle 2; with dout_ready held 1, one beat per cycle thereafter.
REQ-023 SHALL assert busy from the cycle after an accepted start until the cycle after the final beat transfers.
REQ-024 SHALL support a simultaneous FIFO write and read in one cycle with occupancy unchanged.
REQ-025 SHALL use 9-bit row/col counters internally so 255x255 terminates without wrap-around.

Reset
REQ-026 SHALL on rstn low, including mid-transfer: state IDLE, counters 0, FIFO flushed, in-flight read discarded; busy=0, dout_valid=0, dout=0, dout_last=0, sense_en=0, row=0, col=0.

Configuration
REQ-027 SHALL, with IO_TX_LAST_EN defined, carry a last flag per FIFO entry and assert dout_last with the final pixel's beat only.
REQ-028 SHALL, without IO_TX_LAST_EN, tie dout_last to 0 and omit the flag storage; all other behaviour identical.

Structure
REQ-029 SHALL take img_sram_ctrl_t and the 8-bit row/col/data widths from img_sram_pkg; add no new package types.
REQ-030 SHALL place the buffer in sub-module io_tx_fifo (FIFO_DEPTH entries, push/pop/full/empty/count).

Verification
REQ-031 SHALL cover 3x4 image, dout_ready=1: 12 beats in row-major order on cycles 2..13, dout_last on beat 12 only, busy low on cycle 15.
REQ-032 SHALL cover backpressure: 2x2 image, dout_ready low cycles 3..8: at most FIFO_DEPTH reads outstanding, dout stable while stalled, all 4 pixels delivered once.
REQ-033 SHALL cover start with nrows=0, ncols=5: no sense_en, busy stays 0, no dout_valid.
REQ-034 SHALL cover second start pulse during busy: ignored; exactly nrows*ncols beats delivered.
REQ-035 SHALL cover rstn asserted after 5 beats of a 4x4 image: all outputs reset next edge; a new 1x1 start afterwards delivers pixel (0,0) with dout_last=1.
REQ-036 SHALL cover 255x255 with random dout_ready: 65025 beats, correct order, terminates.

Source files
------------

// File: rtl/img_sram_pkg.sv
// Shared image-SRAM definitions: the SRAM control bundle and the row/col/data widths.
package img_sram_pkg;

    localparam int IMG_ROW_W  = 8;
    localparam int IMG_COL_W  = 8;
    localparam int IMG_DATA_W = 8;

    typedef struct packed {
        logic                  sense_en;
        logic                  write_en;
        logic [IMG_ROW_W-1:0]  row;
        logic [IMG_COL_W-1:0]  col;
        logic [IMG_DATA_W-1:0] din;
    } img_sram_ctrl_t;

endpackage

// File: rtl/io_tx_fifo.sv
// Fall-through output buffer: a word pushed into an empty FIFO is visible at the head in the
// same cycle, and a simultaneous push and pop on an empty FIFO leaves the storage untouched.
module io_tx_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             bypass;
    logic             store;
    logic             unload;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bypass  = (count_q == '0);
    assign store   = push_i && !(pop_i && bypass);
    assign unload  = pop_i && !bypass;

    assign empty_o    = bypass && !push_i;
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = bypass ? push_data_i : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (unload) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(store) - CW'(unload);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/io_tx_controller.sv
// Streams an nrows x ncols image out of the image SRAM in row-major order onto a valid/ready port.
// Define IO_TX_LAST_EN to carry a per-pixel last flag and drive dout_last.
module io_tx_controller
    import img_sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [IMG_ROW_W-1:0]  nrows,
    input  logic [IMG_COL_W-1:0]  ncols,
    output img_sram_ctrl_t        sram_ctrl,
    input  logic [IMG_DATA_W-1:0] sram_dout,
    output logic [IMG_DATA_W-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy
);

    // Output handshake: a beat transfers in any cycle where dout_valid && dout_ready; while
    // dout_valid is high and dout_ready low, dout and dout_last hold their values.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

`ifdef IO_TX_LAST_EN
    localparam int FW = IMG_DATA_W + 1;
`else
    localparam int FW = IMG_DATA_W;
`endif
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e               state_q, state_d;
    logic [IMG_ROW_W-1:0] nrows_q, nrows_d;
    logic [IMG_COL_W-1:0] ncols_q, ncols_d;
    logic [IMG_ROW_W:0]   row_q, row_d;
    logic [IMG_COL_W:0]   col_q, col_d;
    logic                 inflight_q;
    logic                 tail_q, tail_d;

    logic                 issue;
    logic                 can_issue;
    logic                 row_end;
    logic                 final_read;
    logic                 xfer;
    logic                 final_beat;
    logic [CW:0]          occupancy;

    logic [FW-1:0]        push_data;
    logic [FW-1:0]        pop_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_valid;
    logic [CW-1:0]        fifo_count;

    // Entries already buffered plus the read whose data arrives next cycle.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign can_issue  = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign row_end    = (col_q + (IMG_COL_W+1)'(1)) == {1'b0, ncols_q};
    assign final_read = row_end && ((row_q + (IMG_ROW_W+1)'(1)) == {1'b0, nrows_q});

    assign fifo_valid = !fifo_empty;
    assign xfer       = fifo_valid && dout_ready;
    assign final_beat = xfer && (occupancy == (CW+1)'(1));

    always_comb begin
        state_d = state_q;
        nrows_d = nrows_q;
        ncols_d = ncols_q;
        row_d   = row_q;
        col_d   = col_q;
        tail_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (nrows != '0) && (ncols != '0)) begin
                    state_d = READ;
                    nrows_d = nrows;
                    ncols_d = ncols;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            READ: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (final_read) begin
                        state_d = DRAIN;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (row_end) begin
                        row_d = row_q + (IMG_ROW_W+1)'(1);
                        col_d = '0;
                    end else begin
                        col_d = col_q + (IMG_COL_W+1)'(1);
                    end
                end
            end
            DRAIN: begin
                if (final_beat) begin
                    state_d = IDLE;
                    tail_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            nrows_q    <= '0;
            ncols_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            tail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nrows_q    <= nrows_d;
            ncols_q    <= ncols_d;
            row_q      <= row_d;
            col_q      <= col_d;
            inflight_q <= issue;
            tail_q     <= tail_d;
        end
    end

    always_comb begin
        sram_ctrl          = '0;
        sram_ctrl.sense_en = issue;
        sram_ctrl.row      = row_q[IMG_ROW_W-1:0];
        sram_ctrl.col      = col_q[IMG_COL_W-1:0];
    end

`ifdef IO_TX_LAST_EN
    logic inflight_last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_last_q <= 1'b0;
        end else begin
            inflight_last_q <= issue && final_read;
        end
    end

    assign push_data = {inflight_last_q, sram_dout};
    assign dout_last = fifo_valid && pop_data[FW-1];
`else
    assign push_data = sram_dout;
    assign dout_last = 1'b0;
`endif

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (xfer),
        .pop_data_o  (pop_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign dout_valid = fifo_valid;
    assign dout       = fifo_valid ? pop_data[IMG_DATA_W-1:0] : '0;
    // Busy stays high for one cycle after the final beat has transferred.
    assign busy       = (state_q != IDLE) || tail_q;

endmodule

// File: tb/tb_io_tx_controller.sv
// Scoreboard bench for io_tx_controller: an SRAM model answers reads, expected pixels and
// read addresses are queued at start, and a negedge monitor checks reads and beats.
`timescale 1ns/1ps
module tb_io_tx_controller;
    import img_sram_pkg::*;

    localparam int DEPTH = 2;

    logic           clk;
    logic           rstn;
    logic           start;
    logic [7:0]     nrows;
    logic [7:0]     ncols;
    img_sram_ctrl_t sram_ctrl;
    logic [7:0]     sram_dout;
    logic [7:0]     dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           dout_last;
    logic           busy;

    int          total;
    int          bad;
    int          reads;
    int          beats;
    logic [8:0]  exp_q[$];
    logic [15:0] addr_q[$];
    logic        prev_stall;
    logic [8:0]  prev_beat;

    io_tx_controller #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .nrows      (nrows),
        .ncols      (ncols),
        .sram_ctrl  (sram_ctrl),
        .sram_dout  (sram_dout),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 31 + c * 7 + 5);
    endfunction

    function automatic logic last_bit(input logic is_last);
`ifdef IO_TX_LAST_EN
        return is_last;
`else
        return 1'b0 & is_last;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM model: data one cycle after the address; garbage when no read is issued.
    always @(posedge clk) begin
        if (sram_ctrl.sense_en) begin
            sram_dout <= pix(int'(sram_ctrl.row), int'(sram_ctrl.col));
        end else begin
            sram_dout <= 8'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            addr_q.delete();
            reads      = 0;
            beats      = 0;
            prev_stall = 1'b0;
            prev_beat  = '0;
        end else begin
            if (sram_ctrl.sense_en) begin
                check("read_credit", 32'((reads - beats) < DEPTH), 32'(1));
                check("write_en_din", 32'({sram_ctrl.write_en, sram_ctrl.din}), 32'(0));
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %0h/%0h expected none", sram_ctrl.row, sram_ctrl.col);
                end else begin
                    check("read_addr", 32'({sram_ctrl.row, sram_ctrl.col}), 32'(addr_q.pop_front()));
                end
                reads++;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(dout_valid), 32'(1));
                check("stall_data", 32'({dout_last, dout}), 32'(prev_beat));
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", dout);
                end else begin
                    check("beat", 32'({dout_last, dout}), 32'(exp_q.pop_front()));
                end
                beats++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_beat  = {dout_last, dout};
        end
    end

    // Queues the expected image and pulses start for one cycle; returns in cycle 1.
    task automatic start_image(input int r, input int c);
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                addr_q.push_back({8'(i), 8'(j)});
                exp_q.push_back({last_bit((i == r - 1) && (j == c - 1)), pix(i, j)});
            end
        end
        nrows = 8'(r);
        ncols = 8'(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_in_budget"}, 32'(n < budget), 32'(1));
        check({name, "_all_reads"}, 32'(addr_q.size()), 32'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_valid"}, 32'(dout_valid), 32'(0));
        check({name, "_dout"}, 32'(dout), 32'(0));
        check({name, "_last"}, 32'(dout_last), 32'(0));
        check({name, "_sense"}, 32'(sram_ctrl.sense_en), 32'(0));
        check({name, "_rowcol"}, 32'({sram_ctrl.row, sram_ctrl.col}), 32'(0));
    endtask

    initial begin
        int base;
        int n;
        total      = 0;
        bad        = 0;
        rstn       = 1'b0;
        start      = 1'b0;
        nrows      = '0;
        ncols      = '0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 3x4 with dout_ready held high: exact cycle profile from start (cycle 0).
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) begin
                addr_q.push_back({8'(i), 8'(j)});
                exp_q.push_back({last_bit((i == 2) && (j == 3)), pix(i, j)});
            end
        end
        nrows = 8'd3;
        ncols = 8'd4;
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("lat_sense", 32'(sram_ctrl.sense_en), 32'((k >= 1) && (k <= 12)));
            check("lat_valid", 32'(dout_valid), 32'((k >= 2) && (k <= 13)));
            check("lat_busy", 32'(busy), 32'((k >= 1) && (k <= 14)));
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done("img3x4", 100);

        // 2x2 with backpressure in cycles 3..8.
        start_image(2, 2);
        for (int k = 1; k < 15; k++) begin
            dout_ready = !((k >= 3) && (k <= 8));
            @(posedge clk);
            #1;
        end
        dout_ready = 1'b1;
        wait_done("bp2x2", 100);

        // Zero-row request is ignored entirely.
        nrows = 8'd0;
        ncols = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("zero_sense", 32'(sram_ctrl.sense_en), 32'(0));
            check("zero_busy", 32'(busy), 32'(0));
            check("zero_valid", 32'(dout_valid), 32'(0));
        end
        @(posedge clk);
        #1;

        // Second start and changed sizes while busy have no effect.
        base = beats;
        start_image(2, 3);
        @(posedge clk);
        #1;
        nrows = 8'd7;
        ncols = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("dbl_start", 100);
        repeat (4) @(posedge clk);
        #1;
        check("dbl_start_beats", 32'(beats - base), 32'(6));

        // Reset after 5 beats of a 4x4 image, then a 1x1 image.
        base = beats;
        start_image(4, 4);
        n = 0;
        while ((beats - base) < 5 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_mid_reached", 32'((beats - base) == 5), 32'(1));
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        start_image(1, 1);
        wait_done("after_rst", 50);
        check("after_rst_beats", 32'(beats), 32'(1));

        // Full 255x255 image with random backpressure.
        base = beats;
        start_image(255, 255);
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 80000) begin
            dout_ready = ($urandom_range(0, 15) != 0);
            @(posedge clk);
            #1;
            n++;
        end
        dout_ready = 1'b1;
        check("big_in_budget", 32'(n < 80000), 32'(1));
        check("big_beats", 32'(beats - base), 32'(65025));
        check("big_reads_left", 32'(addr_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
